// File: rtl/prod_accum_pkg.sv
// Shared constants, FSM state type and saturation helpers for the product accumulator.
package prod_accum_pkg;

  // Cycles from operand capture to product valid (multiplier in/out registers enabled).
  localparam int unsigned MULT_LAT = 2;

  // Default output sample width and the matching saturation limits.
  localparam int unsigned OUT_W_DEFAULT = 18;

  typedef enum logic {
    StEmpty,
    StAcc
  } state_e;

  // Largest value representable in a w-bit two's complement word.
  function automatic longint sat_max(input int unsigned w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  // Smallest value representable in a w-bit two's complement word.
  function automatic longint sat_min(input int unsigned w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  localparam longint SAT_MAX = sat_max(OUT_W_DEFAULT);
  localparam longint SAT_MIN = sat_min(OUT_W_DEFAULT);

endpackage

// File: rtl/valid_pipe.sv
// Valid/last delay line that tracks operands through the multiplier pipeline.
module valid_pipe #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic in_valid,
  input  logic in_last,
  output logic out_valid,
  output logic out_last
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] last_q;

  // last is only meaningful alongside valid, so it is masked on entry.
  if (DEPTH > 1) begin : g_multi
    // Shift the tags forward only when the multiplier advances.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= '0;
        last_q  <= '0;
      end else if (en) begin
        valid_q <= {valid_q[DEPTH-2:0], in_valid};
        last_q  <= {last_q[DEPTH-2:0], in_valid & in_last};
      end
    end
  end else begin : g_single
    // Single-stage variant of the same delay.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= '0;
        last_q  <= '0;
      end else if (en) begin
        valid_q <= in_valid;
        last_q  <= in_valid & in_last;
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_last  = last_q[DEPTH-1];

endmodule

// File: rtl/prod_accum.sv
// Frame accumulator for an external pipelined multiplier: sums products per frame,
// rounds, shifts and saturates the total, and presents it on a valid/ready output.
module prod_accum #(
  parameter int unsigned MULT_LAT = prod_accum_pkg::MULT_LAT,
  parameter int unsigned ACC_W    = 44,
  parameter int unsigned SHIFT    = 17,
  parameter int unsigned OUT_W    = 18
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic                    mult_en,
  input  logic signed [35:0]      prod,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_ovf,
  output logic                    out_valid,
  input  logic                    out_ready
);

  import prod_accum_pkg::*;

  // Term counter keeps one spare bit above the overflow limit and saturates.
  localparam int unsigned CntW = ACC_W - 36 + 2;
  localparam logic [CntW-1:0] CntLim = CntW'(1) << (ACC_W - 36);
  localparam logic [CntW-1:0] CntMax = '1;

  localparam logic signed [ACC_W:0] RndK  = (ACC_W + 1)'(1) << (SHIFT - 1);
  localparam logic signed [ACC_W:0] SatHi = (ACC_W + 1)'(sat_max(OUT_W));
  localparam logic signed [ACC_W:0] SatLo = (ACC_W + 1)'(sat_min(OUT_W));

  state_e state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, prod_ext, sum;
  logic signed [ACC_W:0]   rounded, shifted;
  logic [CntW-1:0]         cnt_q, cnt_d, cnt_inc;
  logic signed [OUT_W-1:0] out_data_q, out_data_d, sat_val;
  logic                    out_ovf_q, out_ovf_d, out_valid_q, out_valid_d, sat_hit;
  logic                    stall, al_valid, al_last, fire;

  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = ~stall;
  assign mult_en  = ~stall;

  valid_pipe #(
    .DEPTH (MULT_LAT)
  ) u_valid_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (mult_en),
    .in_valid  (in_valid & in_ready),
    .in_last   (in_last),
    .out_valid (al_valid),
    .out_last  (al_last)
  );

  // A held aligned term is consumed once, on the cycle the pipeline advances past it.
  assign fire     = al_valid & ~stall;
  assign prod_ext = {{(ACC_W - 36){prod[35]}}, prod};
  assign sum      = ((state_q == StAcc) ? acc_q : '0) + prod_ext;
  assign rounded  = $signed({sum[ACC_W-1], sum}) + RndK;
  assign shifted  = rounded >>> SHIFT;

  // Term count after this product, and the saturated output sample.
  always_comb begin
    cnt_inc = CntW'(1);
    if (state_q == StAcc) begin
      cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
    end
    sat_hit = 1'b0;
    sat_val = shifted[OUT_W-1:0];
    if (shifted > SatHi) begin
      sat_hit = 1'b1;
      sat_val = SatHi[OUT_W-1:0];
    end else if (shifted < SatLo) begin
      sat_hit = 1'b1;
      sat_val = SatLo[OUT_W-1:0];
    end
  end

  // Next-state: accumulate aligned products, load the output register at end of frame.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (fire) begin
      acc_d   = sum;
      cnt_d   = cnt_inc;
      state_d = al_last ? StEmpty : StAcc;
      if (al_last) begin
        out_data_d  = sat_val;
        out_ovf_d   = sat_hit | (cnt_inc > CntLim);
        out_valid_d = 1'b1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_prod_accum.sv
// Directed bench for prod_accum with a behavioural 2-stage multiplier and a result scoreboard.
module tb_prod_accum;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b1;
  logic in_ready, mult_en, out_ovf, out_valid;
  logic signed [17:0] out_data;

  // Multiplier model: operand registers then product register, both on mult_en.
  logic signed [17:0] a = '0, b = '0, a_q = '0, b_q = '0;
  logic signed [35:0] p_q = '0;

  int n_pass = 0;
  int n_total = 0;

  longint exp_sum = 0;
  int     exp_cnt = 0;
  longint exp_data_q[$];
  bit     exp_ovf_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mult_en) begin
      a_q <= a;
      b_q <= b;
      p_q <= a_q * b_q;
    end
  end

  prod_accum dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .mult_en   (mult_en),
    .prod      (p_q),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Reference: round half up at bit 17, arithmetic shift, saturate to 18 bits.
  task automatic model_term(input int av, input int bv, input bit last);
    longint r;
    bit     ovf;
    exp_sum += longint'(av) * longint'(bv);
    exp_cnt++;
    if (last) begin
      r   = (exp_sum + 65536) >>> 17;
      ovf = (exp_cnt > 256);
      if (r > 131071) begin
        r   = 131071;
        ovf = 1'b1;
      end else if (r < -131072) begin
        r   = -131072;
        ovf = 1'b1;
      end
      exp_data_q.push_back(r);
      exp_ovf_q.push_back(ovf);
      exp_sum = 0;
      exp_cnt = 0;
    end
  endtask

  // Hold the presented operands until accepted; returns #1 after the accepting edge.
  task automatic send_wait();
    bit done = 1'b0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic term(input int av, input int bv, input bit last);
    model_term(av, bv, last);
    a        = 18'(av);
    b        = 18'(bv);
    in_valid = 1'b1;
    in_last  = last;
    send_wait();
  endtask

  // Scoreboard: every output handshake pops and compares one expected result.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_data_q.size() == 0) begin
        chk("spurious_out", 1, 0);
      end else begin
        chk("out_data", out_data, exp_data_q.pop_front());
        chk("out_ovf", out_ovf, exp_ovf_q.pop_front());
      end
    end
  end

  initial begin
    logic signed [17:0] held;
    bit seen;

    // Reset state.
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_mult_en", mult_en, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single term and output latency.
    term(65536, 65536, 1);
    chk("lat_t0", out_valid, 0);
    @(posedge clk);
    #1 chk("lat_t1", out_valid, 0);
    @(posedge clk);
    #1 chk("lat_t2", out_valid, 1);
    chk("single_value", out_data, 32768);
    repeat (3) @(posedge clk);
    #1;

    // Rounding of single-term frames.
    term(256, 256, 1);
    term(-65536, 65536, 1);

    // Saturation on a 4-term frame.
    for (int i = 0; i < 4; i++) term(-131072, -131072, i == 3);

    // Back-to-back 3-term then 1-term frame.
    term(100000, 100000, 0);
    term(-50000, 30000, 0);
    term(12345, 6789, 1);
    term(-100000, 90000, 1);
    repeat (5) @(posedge clk);
    #1;

    // in_last without in_valid mid-frame must not close the frame.
    term(1000, 1000, 0);
    in_last = 1'b1;
    repeat (3) @(posedge clk);
    #1 in_last = 1'b0;
    term(2000, -2000, 1);
    repeat (5) @(posedge clk);
    #1;

    // Backpressure with a second frame waiting at the input.
    out_ready = 1'b0;
    term(70000, 70000, 0);
    term(-3000, 4000, 1);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = out_valid;
    end
    chk("bp_result_seen", seen, 1);
    held = out_data;
    model_term(-20000, 15000, 1);
    a        = 18'(-20000);
    b        = 18'(15000);
    in_valid = 1'b1;
    in_last  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_mult_en", mult_en, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data_hold", out_data, held);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send_wait();
    repeat (6) @(posedge clk);
    #1;

    // Reset in the middle of a frame discards the partial sum and in-flight terms.
    term(100000, 100000, 0);
    term(90000, 90000, 0);
    rst_n   = 1'b0;
    exp_sum = 0;
    exp_cnt = 0;
    #2;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    term(65536, 65536, 0);
    term(65536, 65536, 1);

    // Drain the scoreboard.
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(posedge clk);
      seen = (exp_data_q.size() == 0);
    end
    chk("drain_done", seen, 1);
    @(negedge clk);
    chk("idle_out_valid", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/prod_accum.md
PROD_ACCUM -- requirements
Module: prod_accum

Interface
REQ-001 The block SHALL have parameters (name, default, meaning):
- MULT_LAT, 2, cycles from multiplier operand capture to product valid (input and output registers enabled).
- ACC_W, 44, accumulator width in bits.
- SHIFT, 17, right-shift applied to the accumulator before output.
- OUT_W, 18, output sample width in bits.
REQ-002 The block SHALL have one clock, clk; reset is rst_n, asynchronous and active-low.
REQ-003 The block SHALL have ports (name  direction  width  meaning):
- clk  in  1  clock, shared with the multiplier.
- rst_n  in  1  async active-low reset.
- in_valid  in  1  operand pair is being presented to the multiplier this cycle.
- in_last  in  1  qualifies in_valid; marks the final term of a frame.
- in_ready  out  1  block accepts operands this cycle.
- mult_en  out  1  drives the multiplier clock enable.
- prod  in  36  signed multiplier product.
- out_data  out  OUT_W  signed rounded, saturated frame sum.
- out_ovf  out  1  saturation or term-count overflow for the current out_data.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts out_data.

Function
REQ-004 stall SHALL equal out_valid AND NOT out_ready; in_ready and mult_en SHALL both equal NOT stall.
REQ-005 An operand SHALL be accepted when in_valid AND in_ready.
REQ-006 A MULT_LAT-deep valid/last delay line SHALL advance only when mult_en=1, so aligned_valid/aligned_last coincide with the matching prod.
REQ-007 The FSM SHALL have two states: EMPTY and ACC.
REQ-008 In EMPTY, aligned_valid SHALL load acc = sign-extended prod and set term count to 1.
REQ-009 In ACC, aligned_valid SHALL do acc += sign-extended prod and increment the term count.
REQ-010 aligned_valid with aligned_last SHALL return the FSM to EMPTY; otherwise aligned_valid SHALL move to ACC.
REQ-011 On aligned_last, the final sum (including this term) SHALL have 2^(SHIFT-1) added, be arithmetically shifted right by SHIFT, then be saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-012 On aligned_last, the result SHALL load out_data the next cycle with out_valid=1.
REQ-013 out_ovf SHALL be 1 if saturation occurred or the term count exceeded 2^(ACC_W-36).
REQ-014 out_data, out_ovf and out_valid SHALL hold stable while out_valid AND NOT out_ready.
REQ-015 out_valid SHALL clear after a handshake unless a new result loads in the same cycle, in which case the output SHALL reload with no bubble.
REQ-016 A single-term frame (in_valid AND in_last on the first term) SHALL produce that product rounded.
REQ-017 Frames SHALL be back-to-back without idle cycles; the end-of-frame term SHALL NOT mix with the next frame's first term.
REQ-018 in_last without in_valid SHALL be ignored.

Reset
REQ-019 While rst_n=0: FSM=EMPTY, acc=0, term count=0, delay line cleared, out_data=0, out_ovf=0, out_valid=0; in_ready and mult_en follow REQ-004 (both 1).
REQ-020 Reset asserted mid-frame SHALL discard the partial sum and all in-flight products.
REQ-021 After reset deassertion, the first aligned_valid SHALL start a fresh frame.

Structure
REQ-022 A shared package SHALL hold MULT_LAT, the state enumeration, and the saturation limit constants.
REQ-023 The valid/last delay line SHALL be one sub-module, valid_pipe, parameterised by depth, with an enable input.

Verification
REQ-024 Single term A=65536, B=65536, last -> out_data=32768, out_ovf=0, out_valid 1 cycle after aligned_last.
REQ-025 Rounding: single term A=256, B=256 (prod 2^16) -> out_data=1; A=-65536, B=65536 -> out_data=-32768.
REQ-026 Saturation: 4 terms of A=B=-131072 -> out_data=131071, out_ovf=1.
REQ-027 Back-to-back frames: 3-term frame then 1-term frame with out_ready=1 -> two correct results, no cross-contamination.
REQ-028 Backpressure: out_ready=0 for 5 cycles with a second frame pending -> in_ready=0 and mult_en=0; out_data stable; the second result appears after out_ready rises.
REQ-029 rst_n pulsed low mid-frame -> out_valid=0; the next frame's result excludes pre-reset terms.
